// File: rtl/icache_controller.sv
// Direct-mapped instruction cache with a single-block fill controller.
// Hits are served combinationally. A miss stalls the CPU while one 16-byte block is fetched and installed.
module icache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 6 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  valid_r [LINES];
  logic [TAG_BITS-1:0]   tag_r   [LINES];
  logic [127:0]          data_r  [LINES];
  logic [5:0]            miss_block_r;
  logic                  fill_first_r;
  logic [127:0]          fill_data_r;

  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic [INDEX_BITS-1:0] miss_index_s;
  logic [TAG_BITS-1:0]   miss_tag_s;
  logic [127:0]          line_s;
  logic                  hit_s;
  logic                  busy_s;
  logic                  mem_read_s;
  logic [5:0]            mem_address_s;
  logic                  start_s;
  logic                  capture_s;
  logic                  install_s;
  logic                  unused_addr_s;

  assign index_s       = address[3+INDEX_BITS:4];
  assign tag_s         = address[9:4+INDEX_BITS];
  assign miss_index_s  = miss_block_r[INDEX_BITS-1:0];
  assign miss_tag_s    = miss_block_r[5:INDEX_BITS];
  assign line_s        = data_r[index_s];
  assign hit_s         = read & valid_r[index_s] & (tag_r[index_s] == tag_s);
  assign unused_addr_s = ^address[1:0];

  // Word select within the indexed line, straight from the current address.
  always_comb begin
    instruction = 32'd0;
    case (address[3:2])
      2'b00:   instruction = line_s[31:0];
      2'b01:   instruction = line_s[63:32];
      2'b10:   instruction = line_s[95:64];
      2'b11:   instruction = line_s[127:96];
      default: instruction = 32'd0;
    endcase
  end

  // Next-state and control decode for the fill FSM.
  always_comb begin
    state_next_s  = state_r;
    busy_s        = 1'b0;
    mem_read_s    = 1'b0;
    mem_address_s = 6'd0;
    start_s       = 1'b0;
    capture_s     = 1'b0;
    install_s     = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = read & ~hit_s;
        if (read && !hit_s) begin
          start_s      = 1'b1;
          state_next_s = FILL;
        end else begin
          state_next_s = IDLE;
        end
      end
      FILL: begin
        busy_s        = 1'b1;
        mem_read_s    = 1'b1;
        mem_address_s = miss_block_r;
        // The first FILL cycle precedes the memory's busy response, so its handshake is not trusted.
        if (!fill_first_r && !mem_busywait) begin
          capture_s    = 1'b1;
          state_next_s = UPDATE;
        end else begin
          state_next_s = FILL;
        end
      end
      UPDATE: begin
        busy_s       = 1'b1;
        install_s    = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Reset overrides the stall so an aborted fill releases the CPU at once.
  assign busywait    = busy_s & ~reset;
  assign mem_read    = mem_read_s;
  assign mem_address = mem_address_s;

  // FSM state, miss bookkeeping and fill data capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      miss_block_r <= 6'd0;
      fill_first_r <= 1'b0;
      fill_data_r  <= 128'd0;
    end else begin
      state_r      <= state_next_s;
      fill_first_r <= start_s;
      if (start_s) begin
        miss_block_r <= address[9:4];
      end
      if (capture_s) begin
        fill_data_r <= mem_readdata;
      end
    end
  end

  // Line storage; a fill overwrites the indexed line unconditionally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= '0;
        data_r[i]  <= 128'd0;
      end
    end else if (install_s) begin
      valid_r[miss_index_s] <= 1'b1;
      tag_r[miss_index_s]   <= miss_tag_s;
      data_r[miss_index_s]  <= fill_data_r;
    end
  end

endmodule
